xs3_stream_decoder: RTL and testbench

- Decodes a serial stream of excess-3 (XS-3) digits back to a binary integer. It is the receive-side inverse of the team's binary-to-excess-3 converter.
- Accepts one 4-bit XS-3 digit per handshake, most significant digit first. A frame is terminated by a last flag.
- Accumulates the decimal value into a binary result and presents it on a valid/ready output port.
- Flags illegal XS-3 codes and digit-count overflow.

---
 rtl/xs3_stream_decoder_if.sv | 42 ++++
 rtl/xs3_stream_decoder.sv | 117 +++++++++++
 tb/tb_xs3_stream_decoder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/xs3_stream_decoder_if.sv
// rtl/xs3_stream_decoder_if.sv - digit input stream and decoded result port of the XS-3 stream decoder
// XS3_BCD_OUT_EN adds the out_bcd result field (and its NDIGITS parameter).

interface xs3_stream_decoder_if #(
    parameter int BIN_W = 14
`ifdef XS3_BCD_OUT_EN
    , parameter int NDIGITS = 4
`endif
);
    logic [3:0]       in_xs3;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [BIN_W-1:0] out_bin;
    logic [2:0]       out_ndig;
    logic             out_err;
    logic             out_valid;
    logic             out_ready;
`ifdef XS3_BCD_OUT_EN
    logic [4*NDIGITS-1:0] out_bcd;

    modport master (
        output in_xs3, in_valid, in_last, out_ready,
        input  in_ready, out_bin, out_ndig, out_err, out_valid, out_bcd
    );

    modport slave (
        input  in_xs3, in_valid, in_last, out_ready,
        output in_ready, out_bin, out_ndig, out_err, out_valid, out_bcd
    );
`else
    modport master (
        output in_xs3, in_valid, in_last, out_ready,
        input  in_ready, out_bin, out_ndig, out_err, out_valid
    );

    modport slave (
        input  in_xs3, in_valid, in_last, out_ready,
        output in_ready, out_bin, out_ndig, out_err, out_valid
    );
`endif
endinterface

// File: rtl/xs3_stream_decoder.sv
// rtl/xs3_stream_decoder.sv - serial excess-3 digit stream to binary integer decoder
// Optional XS3_BCD_OUT_EN also delivers the accepted digits as right-aligned BCD.

module xs3_stream_decoder #(
    parameter int NDIGITS = 4,
    parameter int BIN_W   = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    xs3_stream_decoder_if.slave bus
);
    localparam logic [2:0] MAX_CNT = 3'(NDIGITS);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state;
    logic [BIN_W-1:0] acc;
    logic [2:0]       count;
    logic             err;

    logic             illegal;
    logic [3:0]       digit;
    logic             accept;
    logic [BIN_W+3:0] acc_x10;
    logic [BIN_W-1:0] acc_nxt;
    logic [2:0]       count_nxt;
    logic             err_nxt;

`ifdef XS3_BCD_OUT_EN
    localparam int BCD_W = 4 * NDIGITS;
    logic [BCD_W-1:0] bcd;
    logic [BCD_W-1:0] bcd_nxt;
`endif

    // in_ready is forced low during reset, otherwise it simply reflects "not holding a result"
    assign bus.in_ready = rst_n && (state != DONE);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        illegal   = (bus.in_xs3 < 4'd3) || (bus.in_xs3 > 4'd12);
        digit     = illegal ? 4'd0 : bus.in_xs3 - 4'd3;
        acc_x10   = ({4'd0, acc} << 3) + ({4'd0, acc} << 1);
        acc_nxt   = acc;
        count_nxt = count;
        err_nxt   = err;
`ifdef XS3_BCD_OUT_EN
        bcd_nxt   = bcd;
`endif
        if (state == IDLE) begin
            acc_nxt   = BIN_W'(digit);
            count_nxt = 3'd1;
            err_nxt   = illegal;
`ifdef XS3_BCD_OUT_EN
            bcd_nxt   = BCD_W'(digit);
`endif
        end else if (count < MAX_CNT) begin
            acc_nxt   = BIN_W'(acc_x10 + (BIN_W + 4)'(digit));
            count_nxt = count + 3'd1;
            err_nxt   = err | illegal;
`ifdef XS3_BCD_OUT_EN
            bcd_nxt   = BCD_W'({bcd, digit});
`endif
        end else begin
            // digit beyond capacity: dropped, frame marked bad
            err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            count         <= '0;
            err           <= 1'b0;
            bus.out_bin   <= '0;
            bus.out_ndig  <= '0;
            bus.out_err   <= 1'b0;
            bus.out_valid <= 1'b0;
`ifdef XS3_BCD_OUT_EN
            bcd           <= '0;
            bus.out_bcd   <= '0;
`endif
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc   <= acc_nxt;
                        count <= count_nxt;
                        err   <= err_nxt;
`ifdef XS3_BCD_OUT_EN
                        bcd   <= bcd_nxt;
`endif
                        if (bus.in_last) begin
                            state         <= DONE;
                            bus.out_bin   <= acc_nxt;
                            bus.out_ndig  <= count_nxt;
                            bus.out_err   <= err_nxt;
                            bus.out_valid <= 1'b1;
`ifdef XS3_BCD_OUT_EN
                            bus.out_bcd   <= bcd_nxt;
`endif
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xs3_stream_decoder.sv
// tb/tb_xs3_stream_decoder.sv - randomized self-checking bench for xs3_stream_decoder
// Optional XS3_BCD_OUT_EN also checks out_bcd.

module tb_xs3_stream_decoder;
    localparam int NDIGITS = 4;
    localparam int BIN_W   = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef XS3_BCD_OUT_EN
    xs3_stream_decoder_if #(.BIN_W(BIN_W), .NDIGITS(NDIGITS)) bus ();
`else
    xs3_stream_decoder_if #(.BIN_W(BIN_W)) bus ();
`endif

    xs3_stream_decoder #(.NDIGITS(NDIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [3:0] frame_q[$];

    task automatic send_digit(input logic [3:0] code, input bit last);
        int budget = 0;
        @(negedge clk);
        bus.in_xs3   = code;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (bus.in_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL send_digit_timeout: in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Sends frame_q with random idle gaps, then checks the result one clock after the last digit.
    task automatic run_frame(input string name, input int gap_max);
        longint exp_acc = 0;
        longint exp_bcd = 0;
        int     exp_n   = 0;
        bit     exp_err = 1'b0;
        int     d;
        foreach (frame_q[i]) begin
            if (frame_q[i] >= 3 && frame_q[i] <= 12) begin
                d = int'(frame_q[i]) - 3;
            end else begin
                d = 0;
                exp_err = 1'b1;
            end
            if (exp_n < NDIGITS) begin
                exp_acc = exp_acc * 10 + d;
                exp_bcd = exp_bcd * 16 + d;
                exp_n++;
            end else begin
                exp_err = 1'b1;
            end
        end
        foreach (frame_q[i]) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            send_digit(frame_q[i], i == frame_q.size() - 1);
        end
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s out_valid: got %b want 1", name, bus.out_valid);
        end
        tests++;
        if (bus.out_bin !== BIN_W'(exp_acc)) begin
            fails++;
            $display("FAIL %s out_bin: got %0d want %0d", name, bus.out_bin, exp_acc);
        end
        tests++;
        if (bus.out_ndig !== 3'(exp_n)) begin
            fails++;
            $display("FAIL %s out_ndig: got %0d want %0d", name, bus.out_ndig, exp_n);
        end
        tests++;
        if (bus.out_err !== exp_err) begin
            fails++;
            $display("FAIL %s out_err: got %b want %b", name, bus.out_err, exp_err);
        end
`ifdef XS3_BCD_OUT_EN
        tests++;
        if (bus.out_bcd !== (4 * NDIGITS)'(exp_bcd)) begin
            fails++;
            $display("FAIL %s out_bcd: got %h want %h", name, bus.out_bcd, exp_bcd);
        end
`endif
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_bin !== '0 ||
            bus.out_ndig !== '0 || bus.out_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b out_bin=%0d out_ndig=%0d out_err=%b want all 0",
                     bus.in_ready, bus.out_valid, bus.out_bin, bus.out_ndig, bus.out_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        frame_q = '{4'b0100, 4'b0101, 4'b0110};
        run_frame("basic_123", 0);
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_bin !== 14'd123) begin
            fails++;
            $display("FAIL basic_back_to_idle: out_valid=%b in_ready=%b out_bin=%0d want 0 1 123",
                     bus.out_valid, bus.in_ready, bus.out_bin);
        end
    endtask

    task automatic test_boundaries();
        frame_q = '{4'b1100, 4'b1100, 4'b1100, 4'b1100};
        run_frame("max_9999", 0);
        tests++;
        if (bus.out_bin !== 14'h270F) begin
            fails++;
            $display("FAIL max_9999_const: got %h want 270f", bus.out_bin);
        end
        frame_q = '{4'b0011};
        run_frame("single_zero", 1);
        frame_q = '{4'b0100, 4'b0010, 4'b0111};
        run_frame("illegal_104", 0);
        tests++;
        if (bus.out_bin !== 14'd104 || bus.out_err !== 1'b1) begin
            fails++;
            $display("FAIL illegal_104_const: out_bin=%0d out_err=%b want 104 1", bus.out_bin, bus.out_err);
        end
        frame_q = '{4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000};
        run_frame("overflow_1234", 0);
        tests++;
        if (bus.out_bin !== 14'd1234 || bus.out_ndig !== 3'd4 || bus.out_err !== 1'b1) begin
            fails++;
            $display("FAIL overflow_const: out_bin=%0d out_ndig=%0d out_err=%b want 1234 4 1",
                     bus.out_bin, bus.out_ndig, bus.out_err);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        bus.out_ready = 1'b0;
        frame_q = '{4'b0111, 4'b1000};
        run_frame("bp_frame_45", 2);
        bus.in_xs3   = 4'b0101;
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            tests++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_bin !== 14'd45) begin
                fails++;
                $display("FAIL bp_hold: in_ready=%b out_valid=%b out_bin=%0d want 0 1 45",
                         bus.in_ready, bus.out_valid, bus.out_bin);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_bin !== 14'd45) begin
            fails++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b out_bin=%0d want 0 1 45",
                     bus.out_valid, bus.in_ready, bus.out_bin);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_bin !== 14'd2 || bus.out_ndig !== 3'd1) begin
            fails++;
            $display("FAIL bp_restart: out_valid=%b out_bin=%0d out_ndig=%0d want 1 2 1",
                     bus.out_valid, bus.out_bin, bus.out_ndig);
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 25; f++) begin
            int len = $urandom_range(1, 6);
            frame_q.delete();
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 7) == 0) frame_q.push_back(4'($urandom_range(0, 15)));
                else                          frame_q.push_back(4'($urandom_range(3, 12)));
            end
            run_frame("random", 3);
        end
    endtask

    task automatic test_reset_midframe();
        send_digit(4'b0100, 1'b0);
        send_digit(4'b0101, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.out_bin !== '0 || bus.in_ready !== 1'b0 || bus.out_ndig !== '0) begin
            fails++;
            $display("FAIL reset_midframe: out_valid=%b out_bin=%0d in_ready=%b out_ndig=%0d want 0 0 0 0",
                     bus.out_valid, bus.out_bin, bus.in_ready, bus.out_ndig);
        end
        @(negedge clk);
        rst_n = 1'b1;
        frame_q = '{4'b0100};
        run_frame("after_reset_1", 0);
        tests++;
        if (bus.out_bin !== 14'd1 || bus.out_ndig !== 3'd1) begin
            fails++;
            $display("FAIL after_reset_const: out_bin=%0d out_ndig=%0d want 1 1", bus.out_bin, bus.out_ndig);
        end
    endtask

    initial begin
        bus.in_xs3    = 4'd0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_boundaries();
        test_backpressure();
        test_random_frames();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
